// File: rtl/rr_req_queue.sv
`default_nettype none
// ============================================================================
//  Module  : rr_req_queue
//  Brief   : Four per-port request FIFOs feeding a round-robin arbiter (r out,
//            one-hot g in) and a single registered valid/ready output channel.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_req_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      r,
    input  logic [3:0]      g,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_port,
    input  logic            out_ready,
    output logic            slot_lost
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [DW-1:0] w_head [4];
    logic [3:0]    w_push;
    logic [3:0]    w_pop;
    logic          w_grant_valid;
    logic [1:0]    w_grant_idx;
    logic          w_out_free;
    logic          w_lost;

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [1:0]    r_out_port;
    logic          r_slot_lost;

    // Only an exact one-hot grant counts; zero, multi-hot and unknown values fall to default.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        case (g)
            4'b0001: begin w_grant_valid = 1'b1; w_grant_idx = 2'd0; end
            4'b0010: begin w_grant_valid = 1'b1; w_grant_idx = 2'd1; end
            4'b0100: begin w_grant_valid = 1'b1; w_grant_idx = 2'd2; end
            4'b1000: begin w_grant_valid = 1'b1; w_grant_idx = 2'd3; end
            default: ;
        endcase
    end

    assign w_out_free = !r_out_valid || out_ready;

    always_comb begin
        w_pop = 4'b0000;
        if (w_grant_valid && r[w_grant_idx] && w_out_free) begin
            w_pop = 4'b0001 << w_grant_idx;
        end
    end

    assign w_lost = w_grant_valid && (w_pop == 4'b0000);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_port
            logic [DW-1:0] r_mem [DEPTH];
            logic [AW-1:0] r_wr_ptr;
            logic [AW-1:0] r_rd_ptr;
            logic [CW-1:0] r_count;

            // A full FIFO refuses a push even when it pops in the same cycle.
            assign in_ready[i] = (r_count != c_full_count);
            assign r[i]        = (r_count != '0);
            assign w_push[i]   = in_valid[i] && in_ready[i];
            assign w_head[i]   = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (w_push[i]) begin
                    r_mem[r_wr_ptr] <= in_data[i*DW +: DW];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end
                    if (w_pop[i]) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                    case ({w_push[i], w_pop[i]})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_port  <= 2'd0;
            r_slot_lost <= 1'b0;
        end else begin
            r_slot_lost <= w_lost;
            if (w_pop != 4'b0000) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head[w_grant_idx];
                r_out_port  <= w_grant_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_port  = r_out_port;
    assign slot_lost = r_slot_lost;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rr_req_queue
//  Brief   : Directed self-checking bench with a round-robin arbiter model and
//            an output scoreboard for rr_req_queue.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rr_req_queue;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  r;
    logic [3:0]  g;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        out_ready;
    logic        slot_lost;

    logic        use_arb;
    logic        arb_en;
    logic [3:0]  g_force;
    logic [3:0]  arb_g;
    logic [1:0]  arb_last;
    logic [3:0]  arb_next;
    logic [1:0]  arb_next_idx;
    logic [1:0]  arb_i;

    int          n_err;
    int          n_checks;
    logic [9:0]  sb [$];
    logic [9:0]  sb_exp;
    logic [3:0]  bad_g [4];

    rr_req_queue #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .r         (r),
        .g         (g),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready),
        .slot_lost (slot_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered round-robin arbiter: searches from the port after the last grant.
    always_comb begin
        arb_next     = 4'b0000;
        arb_next_idx = arb_last;
        arb_i        = arb_last;
        for (int k = 4; k >= 1; k--) begin
            arb_i = arb_last + 2'(k);
            if (r[arb_i]) begin
                arb_next     = 4'b0001 << arb_i;
                arb_next_idx = arb_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_g    <= 4'b0000;
            arb_last <= 2'd3;
        end else if (!arb_en) begin
            arb_g    <= 4'b0000;
        end else begin
            arb_g    <= arb_next;
            arb_last <= arb_next_idx;
        end
    end

    assign g = use_arb ? arb_g : g_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any beat completing at the coming edge, then return just after it.
    task automatic cyc();
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("out_data", 32'(out_data), 32'(sb_exp[7:0]));
                check("out_port", 32'(out_port), 32'(sb_exp[9:8]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err    = 0;
        n_checks = 0;
        reset    = 1'b1;
        in_valid = 4'b0000;
        in_data  = 32'h0;
        out_ready = 1'b1;
        use_arb  = 1'b1;
        arb_en   = 1'b0;
        g_force  = 4'b0000;
        bad_g[0] = 4'b0000;
        bad_g[1] = 4'b0011;
        bad_g[2] = 4'b1111;
        bad_g[3] = 4'bxxxx;

        // Reset state
        cyc();
        cyc();
        check("rst_r", 32'(r), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'hf);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_slot_lost", 32'(slot_lost), 32'h0);
        reset  = 1'b0;
        arb_en = 1'b1;
        cyc();

        // Single port latency with the arbiter in the loop
        in_valid = 4'b0100;
        in_data  = 32'h00a5_0000;
        sb.push_back({2'd2, 8'ha5});
        cyc();
        in_valid = 4'b0000;
        check("lat_r_c1", 32'(r), 32'h4);
        check("lat_ov_c1", 32'(out_valid), 32'h0);
        cyc();
        check("lat_g_c2", 32'(g), 32'h4);
        check("lat_ov_c2", 32'(out_valid), 32'h0);
        cyc();
        check("lat_ov_c3", 32'(out_valid), 32'h1);
        check("lat_data_c3", 32'(out_data), 32'ha5);
        check("lat_port_c3", 32'(out_port), 32'h2);
        check("lat_r_c3", 32'(r), 32'h0);
        cyc();
        check("lat_lost_c4", 32'(slot_lost), 32'h1);
        check("lat_ov_c4", 32'(out_valid), 32'h0);
        cyc();
        check("lat_lost_c5", 32'(slot_lost), 32'h0);
        check("lat_sb", 32'(sb.size()), 32'h0);

        // Invalid grants with every FIFO full
        use_arb = 1'b0;
        arb_en  = 1'b0;
        g_force = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b1111;
            in_data  = {8'hf0 + 8'(k), 8'he0 + 8'(k), 8'hd0 + 8'(k), 8'hc0 + 8'(k)};
            cyc();
        end
        in_valid = 4'b0000;
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_r", 32'(r), 32'hf);
        for (int j = 0; j < 4; j++) begin
            g_force = bad_g[j];
            cyc();
            cyc();
            check("badg_out_valid", 32'(out_valid), 32'h0);
            check("badg_slot_lost", 32'(slot_lost), 32'h0);
            check("badg_in_ready", 32'(in_ready), 32'h0);
            check("badg_r", 32'(r), 32'hf);
        end

        // Reset mid-operation with data in flight
        g_force   = 4'b0001;
        out_ready = 1'b0;
        cyc();
        check("mid_ov", 32'(out_valid), 32'h1);
        check("mid_data", 32'(out_data), 32'hc0);
        cyc();
        check("mid_lost", 32'(slot_lost), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_r", 32'(r), 32'h0);
        check("arst_ov", 32'(out_valid), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'hf);
        check("arst_lost", 32'(slot_lost), 32'h0);
        check("arst_data", 32'(out_data), 32'h0);
        cyc();
        reset     = 1'b0;
        g_force   = 4'b0000;
        out_ready = 1'b1;
        use_arb   = 1'b1;
        arb_en    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_rst_ov", 32'(out_valid), 32'h0);
            check("post_rst_r", 32'(r), 32'h0);
        end

        // Fairness: two entries per port drained by the arbiter
        arb_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 4'b1111;
            in_data  = {8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k), 8'h00 + 8'(k)};
            cyc();
        end
        in_valid = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                sb.push_back({2'(i), 8'(i * 16 + k)});
            end
        end
        arb_en = 1'b1;
        for (int t = 0; t < 30 && sb.size() != 0; t++) cyc();
        check("fair_drained", 32'(sb.size()), 32'h0);
        cyc();
        check("fair_r", 32'(r), 32'h0);
        arb_en = 1'b0;
        cyc();
        cyc();

        // Backpressure on a granted, non-empty port
        use_arb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0010;
            in_data  = {16'h0, 8'h11 + 8'(k), 8'h0};
            sb.push_back({2'd1, 8'h11 + 8'(k)});
            cyc();
        end
        in_valid  = 4'b0000;
        g_force   = 4'b0010;
        out_ready = 1'b0;
        cyc();
        check("bp_ov", 32'(out_valid), 32'h1);
        check("bp_lost_first", 32'(slot_lost), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("bp_data", 32'(out_data), 32'h11);
            check("bp_port", 32'(out_port), 32'h1);
            check("bp_lost", 32'(slot_lost), 32'h1);
            check("bp_r", 32'(r), 32'h2);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 10 && sb.size() != 0; t++) cyc();
        check("bp_drained", 32'(sb.size()), 32'h0);
        g_force = 4'b0000;
        cyc();
        cyc();
        check("bp_r_end", 32'(r), 32'h0);

        // Full and pointer wrap on port 0
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b0001;
            in_data  = {24'h0, 8'h50 + 8'(k)};
            if (k < 4) begin
                check("wrap_ready", 32'(in_ready[0]), 32'h1);
                sb.push_back({2'd0, 8'h50 + 8'(k)});
            end else begin
                check("wrap_refuse", 32'(in_ready[0]), 32'h0);
            end
            cyc();
        end
        in_valid = 4'b0000;
        g_force  = 4'b0001;
        for (int t = 0; t < 10 && sb.size() != 0; t++) cyc();
        check("wrap_drain1", 32'(sb.size()), 32'h0);
        g_force = 4'b0000;
        cyc();
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001;
            in_data  = {24'h0, 8'h60 + 8'(k)};
            sb.push_back({2'd0, 8'h60 + 8'(k)});
            cyc();
        end
        in_valid = 4'b0000;
        check("refill_full", 32'(in_ready[0]), 32'h0);
        g_force = 4'b0001;
        cyc();
        check("pushpop_ready", 32'(in_ready[0]), 32'h1);
        in_valid = 4'b0001;
        in_data  = {24'h0, 8'h70};
        sb.push_back({2'd0, 8'h70});
        cyc();
        in_valid = 4'b0000;
        check("pushpop_count", 32'(r[0]), 32'h1);
        for (int t = 0; t < 12 && sb.size() != 0; t++) cyc();
        check("wrap_drain2", 32'(sb.size()), 32'h0);
        g_force = 4'b0000;
        cyc();
        check("wrap_r_end", 32'(r), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_req_queue.md
Name: rr_req_queue

Overview:
- Request front-end for the 4-way round-robin arbiter.
- Buffers transactions from four requester ports in per-port FIFOs and drives the arbiter request vector r (FIFO non-empty).
- Consumes the arbiter's one-hot grant g to pop the granted FIFO into a single registered output channel with valid/ready handshake.
- Sits between the four requesters and the shared downstream resource; the arbiter sits beside it (r out, g in).

Parameters:
- DW, 8, data width per port.
- DEPTH, 4, entries per port FIFO; power of 2, >= 2.
- AW, log2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  4  per-port push request.
- in_data  input  4*DW  per-port data; port i occupies bits [i*DW +: DW].
- in_ready  output  4  per-port not-full.
- r  output  4  request vector to arbiter; r[i] = FIFO i non-empty.
- g  input  4  grant vector from arbiter; one-hot expected.
- out_valid  output  1  output register holds valid data.
- out_data  output  DW  popped data.
- out_port  output  2  index of the source port of out_data.
- out_ready  input  1  downstream accepts.
- slot_lost  output  1  one-cycle pulse when a grant slot is wasted.

Behaviour:
- Reset (async): all FIFO pointers and counts = 0, in_ready = 4'b1111, r = 0, out_valid = 0, out_data = 0, out_port = 0, slot_lost = 0. Reset mid-operation discards all buffered and in-flight data.
- Push: port i pushes when in_valid[i] && in_ready[i]. Data is written at the tail; the count increments next edge.
- in_ready[i]:
  - = (count_i != DEPTH), from registered count.
  - No same-cycle pop-to-push bypass: a full FIFO refuses a push even in a cycle where it pops.
- r[i] = (count_i != 0), from registered count.
  - The arbiter registers its state from r, so a grant arrives 1 cycle after r rises.
- Grant validity: g is accepted only if it is exactly one-hot. Values 0000 or multi-hot, including an undefined idle grant, are treated as no grant. Such values are never a pop and never set slot_lost.
- Pop condition for port i, all of:
  - g one-hot with g[i] = 1;
  - count_i != 0;
  - output register free, i.e. out_valid == 0 || out_ready == 1.
- Pop effect, next edge:
  - out_data <= head_i, out_port <= i, out_valid <= 1;
  - head pointer advances (wraps modulo DEPTH);
  - count_i decrements.
- Simultaneous push and pop on the same port: count is unchanged, and both pointers advance.
- Output handshake:
  - The transfer completes when out_valid && out_ready.
  - If there is no pop in the same cycle, out_valid <= 0.
  - While out_valid && !out_ready, out_data and out_port hold stable.
- slot_lost is pulsed (registered, 1 cycle) when a one-hot g targets port i but the pop condition fails, because either:
  - count_i == 0: a stale grant, since the arbiter may re-grant a port whose last entry popped in the previous cycle; or
  - the output is stalled.
  - A lost grant is not retried by this block; the arbiter simply advances.
- Wrap-around: pointers are AW bits and wrap naturally. Count is AW+1 bits, range 0..DEPTH.
- Ordering: per-port FIFO order is preserved. Cross-port order is defined solely by g.
- Throughput: max 1 pop per cycle total, 1 output beat per cycle with out_ready held high.
- Latency: a push at edge t gives r at t+1. The grant appears at t+2 and the pop occurs in that cycle, so out_valid = 1 from edge t+3.

Test Plan:
- Reset: assert reset mid-burst with FIFOs partly full → immediately r=0, out_valid=0, in_ready=1111, slot_lost=0; after release, no stale data appears.
- Single port, with the arbiter connected: port 2 pushes 0xA5 at cycle 0 → r=0100 at cycle 1, g=0100 at cycle 2, out_valid=1/out_data=0xA5/out_port=2 at cycle 3; the stale re-grant at cycle 3 gives slot_lost=1 at cycle 4.
- Fairness: all four FIFOs hold 2 entries each, out_ready=1 → out_port sequence 0,1,2,3,0,1,2,3; 8 beats out, then r=0000.
- Backpressure: out_ready=0 for 3 cycles while g=0010 with port 1 non-empty → out_data/out_port stable, port 1 count unchanged, slot_lost pulses each granted cycle; out_ready=1 → transfer resumes.
- Full/wrap: push DEPTH+1 (5) entries to port 0 → in_ready[0]=0 after 4, 5th refused; drain 4 and refill 4 → data order correct across pointer wrap.
- Invalid grant: force g=0000, 0011, 1111 with all FIFOs non-empty → no pop, out_valid stays 0, slot_lost=0, counts unchanged.
